usb_cmd_parser: RTL and testbench
=================================

# usb_cmd_parser

Byte-stream command parser that sits directly downstream of the USB comm controller's receive path. It consumes the byte strobe (`read_data`/`received`) and frames bytes into commands. It buffers each payload and issues a one-cycle command strobe to the reservoir control logic. For the transmit opcode it raises a one-cycle `start_tx` pulse that drives the controller's `write_sig`.

## Interface
Parameters:
- `MAX_PAYLOAD`, 16: payload buffer depth in bytes, 1..255. Local `AW = max(1, $clog2(MAX_PAYLOAD))`.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `OP_START`, 8'h02: opcode that also pulses `start_tx`.
- `TIMEOUT_CYCLES`, 5_000_000: maximum inter-byte gap inside a frame (100 ms at 50 MHz), ≥2.

Ports:
- `CLOCK_50`, in, 1: sole clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `rx_data`, in, 8: received byte; valid only when `rx_valid`=1.
- `rx_valid`, in, 1: byte strobe, one cycle per byte (the controller's `received`).
- `buf_rd_addr`, in, AW: payload buffer read address.
- `buf_rd_data`, out, 8: combinational read of payload byte `buf_rd_addr`.
- `cmd_valid`, out, 1: one-cycle pulse, frame accepted.
- `cmd_op`, out, 8: opcode of the last accepted frame.
- `cmd_len`, out, 8: payload length of the last accepted frame.
- `start_tx`, out, 1: one-cycle pulse, coincident with `cmd_valid` when `cmd_op`==`OP_START`.
- `frame_err`, out, 1: one-cycle pulse on frame abort.
- `err_code`, out, 2: cause of the last abort. 1=length, 2=checksum, 3=timeout. Holds until the next abort.
- `busy`, out, 1: high whenever state ≠ HUNT.

## Operation
- Frame format: SYNC, CMD, LEN, LEN payload bytes, then CHK (present only with the checksum feature).
- States and transitions:
  - HUNT: a byte equal to SYNC_BYTE goes to GET_CMD. Any other byte is discarded silently.
  - GET_CMD: latch the opcode, go to GET_LEN.
  - GET_LEN: if LEN > MAX_PAYLOAD, abort with code 1. Otherwise latch LEN.
    - LEN=0: go to GET_CHK, or accept immediately without checksum.
    - LEN>0: go to GET_PAYLOAD.
  - GET_PAYLOAD: write byte i to buffer[i] and increment i. At i==LEN-1, go to GET_CHK, or accept without checksum.
  - GET_CHK: compare with the running XOR. Match accepts, mismatch aborts with code 2.
- Running XOR: cleared in HUNT; accumulates CMD, LEN and every payload byte.
- Accept: pulse `cmd_valid` and update `cmd_op`/`cmd_len`, pulse `start_tx` if applicable, then return to HUNT.
- Abort: pulse `frame_err`, set `err_code`, return to HUNT. `cmd_op`/`cmd_len` are unchanged.
- SYNC_BYTE received mid-frame is treated as ordinary data; there is no resynchronisation.
- The buffer is not cleared. After `cmd_valid`, its contents stay stable until the first payload byte of the next frame.

## Timing
- Every `rx_valid` byte is consumed in its own cycle; the block never back-pressures.
- The final frame byte is accepted at edge N. `cmd_valid`, `start_tx` and `frame_err` are registered and high during cycle N+1 only.
- `busy` rises the cycle after SYNC is accepted and falls with the accept or abort pulse.
- Timeout counter:
  - Cleared on every `rx_valid`; counts while not in HUNT.
  - On reaching TIMEOUT_CYCLES-1 without a byte: abort with code 3 next cycle.
  - `rx_valid` in the expiry cycle: the byte wins, is processed normally, and no timeout fires.
- Back-to-back frames: a SYNC byte arriving in the cycle of the `cmd_valid` pulse is accepted, since state is already HUNT.
- Reset values:
  - All pulses, `busy`, `err_code`, `cmd_op` and `cmd_len` are 0; state is HUNT; the counter and XOR are cleared.
  - A reset mid-frame drops the partial frame with no `frame_err`.
  - Buffer contents are undefined after reset.

## Configuration
- `USB_CMD_CHECKSUM_EN` defined: CHK byte is expected and verified, and error code 2 is possible.
- Undefined: no CHK state or XOR logic. A frame completes on its last payload byte, or on LEN when LEN=0. `err_code` never equals 2.

## Structure
- Package `usb_cmd_pkg`:
  - state enum
  - error-code constants (ERR_LEN=1, ERR_CHK=2, ERR_TIMEOUT=3)
  - default SYNC and opcode constants
- One sub-module: `cmd_payload_buf`, a MAX_PAYLOAD×8 register array with a synchronous write and an asynchronous read port.

## Test plan
- Frame A5 02 02 11 22, plus CHK 33 if enabled → `cmd_valid`=`start_tx`=1 for one cycle. `cmd_op`=02, `cmd_len`=2, buf[0]=11, buf[1]=22.
- Bytes 00 FF then A5 05 00 (CHK 05) → junk ignored. `cmd_valid` with op 05, len 0, `start_tx`=0.
- A5 01 11 with MAX_PAYLOAD=16 → `frame_err`, `err_code`=1, `busy`=0. Then A5 01 00 (CHK 01) → accepted.
- With checksum enabled: A5 01 01 7E then CHK 00 → `err_code`=2, `cmd_op` unchanged.
- TIMEOUT_CYCLES=8: A5 03 then idle → `frame_err`, `err_code`=3, 8 cycles after 03. Repeat with a byte exactly at expiry → no error.
- Reset asserted after A5 03 → `busy`=0 next cycle, no `frame_err`. Then a full frame → accepted.

Source files
------------

// File: rtl/usb_cmd_pkg.sv
// usb_cmd_pkg: shared parser state encoding, abort cause codes and default framing bytes
package usb_cmd_pkg;
  typedef enum logic [2:0] {
    HUNT        = 3'd0,
    GET_CMD     = 3'd1,
    GET_LEN     = 3'd2,
    GET_PAYLOAD = 3'd3,
    GET_CHK     = 3'd4
  } state_t;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_OP_START  = 8'h02;
endpackage

// File: rtl/cmd_payload_buf.sv
// cmd_payload_buf: DEPTHx8 payload store, synchronous write, asynchronous read
// Ports: clk; we/wr_addr/wr_data write port; rd_addr -> rd_data combinational read.
module cmd_payload_buf #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser: frames a SYNC/CMD/LEN/payload[/CHK] byte stream into one-cycle command strobes
// Ports: CLOCK_50, reset (sync, active-high); rx_data/rx_valid byte strobe;
//   buf_rd_addr -> buf_rd_data payload read; cmd_valid/cmd_op/cmd_len accepted command;
//   start_tx pulse for OP_START; frame_err/err_code abort report; busy while a frame is open.
// Define USB_CMD_CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module usb_cmd_parser
  import usb_cmd_pkg::*;
#(
  parameter int MAX_PAYLOAD = 16,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter logic [7:0] OP_START = DEF_OP_START,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  localparam int AW = MAX_PAYLOAD > 1 ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic [AW-1:0] buf_rd_addr,
  output logic [7:0]    buf_rd_data,
  output logic          cmd_valid,
  output logic [7:0]    cmd_op,
  output logic [7:0]    cmd_len,
  output logic          start_tx,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic          busy
);
  localparam logic [7:0]  MAX_LEN  = 8'(MAX_PAYLOAD);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t state, nxt;
  logic [7:0] op, len, idx;
  logic [31:0] tmo;
  logic acc, abt, wr;
  logic [1:0] code;
`ifdef USB_CMD_CHECKSUM_EN
  logic [7:0] xsum;
`endif
  always_comb begin
    nxt = state;
    acc = 1'b0;
    abt = 1'b0;
    wr = 1'b0;
    code = ERR_LEN;
    if (rx_valid)
      case (state)
        HUNT: nxt = rx_data == SYNC_BYTE ? GET_CMD : HUNT;
        GET_CMD: nxt = GET_LEN;
        GET_LEN: begin
          abt = rx_data > MAX_LEN;
`ifdef USB_CMD_CHECKSUM_EN
          nxt = rx_data == 8'd0 ? GET_CHK : GET_PAYLOAD;
`else
          acc = rx_data == 8'd0;
          nxt = GET_PAYLOAD;
`endif
        end
        GET_PAYLOAD: begin
          wr = 1'b1;
`ifdef USB_CMD_CHECKSUM_EN
          nxt = idx + 8'd1 == len ? GET_CHK : GET_PAYLOAD;
`else
          acc = idx + 8'd1 == len;
`endif
        end
`ifdef USB_CMD_CHECKSUM_EN
        GET_CHK: begin
          acc = rx_data == xsum;
          abt = !acc;
          code = ERR_CHK;
        end
`endif
        default: nxt = HUNT;
      endcase
    else if (state != HUNT && tmo == TMO_LAST) begin
      abt = 1'b1;
      code = ERR_TIMEOUT;
    end
    if (acc || abt) nxt = HUNT;
  end
  always_ff @(posedge CLOCK_50) begin
    cmd_valid <= 1'b0;
    start_tx <= 1'b0;
    frame_err <= 1'b0;
    if (reset) begin
      state <= HUNT;
      tmo <= '0;
      op <= '0;
      len <= '0;
      idx <= '0;
      cmd_op <= '0;
      cmd_len <= '0;
      err_code <= '0;
    end else begin
      state <= nxt;
      tmo <= rx_valid || state == HUNT ? '0 : tmo + 32'd1;
      if (rx_valid && state == GET_CMD) op <= rx_data;
      if (rx_valid && state == GET_LEN) begin
        len <= rx_data;
        idx <= '0;
      end
      if (wr) idx <= idx + 8'd1;
      cmd_valid <= acc;
      frame_err <= abt;
      start_tx <= acc && op == OP_START;
      if (acc) begin
        cmd_op <= op;
        cmd_len <= state == GET_LEN ? rx_data : len;
      end
      if (abt) err_code <= code;
    end
  end
`ifdef USB_CMD_CHECKSUM_EN
  always_ff @(posedge CLOCK_50)
    if (reset || state == HUNT) xsum <= '0;
    else if (rx_valid) xsum <= xsum ^ rx_data;
`endif
  assign busy = state != HUNT;
  cmd_payload_buf #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_buf (
    .clk(CLOCK_50),
    .we(wr),
    .wr_addr(idx[AW-1:0]),
    .wr_data(rx_data),
    .rd_addr(buf_rd_addr),
    .rd_data(buf_rd_data)
  );
endmodule

// File: tb/tb_usb_cmd_parser.sv
// tb_usb_cmd_parser: scoreboard bench for usb_cmd_parser against a frame-level reference model
`timescale 1ns/100ps
module tb_usb_cmd_parser;
  localparam int MAXP = 16;
  localparam int T = 8;
  localparam int AW = 4;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] OPS = 8'h02;
`ifdef USB_CMD_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [AW-1:0] buf_rd_addr = '0;
  logic [7:0] buf_rd_data, cmd_op, cmd_len;
  logic cmd_valid, start_tx, frame_err, busy;
  logic [1:0] err_code;
  usb_cmd_parser #(.MAX_PAYLOAD(MAXP), .SYNC_BYTE(SYNC), .OP_START(OPS), .TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .start_tx(start_tx), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );
  always #50 CLOCK_50 = ~CLOCK_50;
  int cyc = 0;
  always @(posedge CLOCK_50) cyc++;
  int tests = 0, fails = 0;
  bit in_f = 1'b0;
  int last_d = 0;
  logic [7:0] fq[$], sq[$], exp_pl[$];
  logic [7:0] m_op = 8'h00, m_len = 8'h00;
  logic [1:0] m_code = 2'd0;
  bit exp_err[$], exp_stx[$];
  int exp_at[$];
  logic [7:0] exp_op[$], exp_len[$];
  logic [1:0] exp_code[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic push_exp(input bit err, input int at, input bit stx, input logic [1:0] code);
    exp_err.push_back(err);
    exp_at.push_back(at);
    exp_stx.push_back(stx);
    exp_code.push_back(code);
    exp_op.push_back(m_op);
    exp_len.push_back(m_len);
  endtask
  // Frame-level model: collect bytes after SYNC and decide once the frame is long enough.
  task automatic model_byte(input logic [7:0] b, input int c);
    logic [7:0] x;
    last_d = c;
    if (!in_f) begin
      if (b == SYNC) begin
        in_f = 1'b1;
        fq.delete();
      end
      return;
    end
    fq.push_back(b);
    if (fq.size() == 2 && fq[1] > MAXP) begin
      in_f = 1'b0;
      m_code = 2'd1;
      push_exp(1'b1, c + 1, 1'b0, 2'd1);
    end else if (fq.size() >= 2 && fq.size() == 2 + int'(fq[1]) + CHK) begin
      in_f = 1'b0;
      x = 8'h00;
      for (int i = 0; i < fq.size() - 1; i++) x ^= fq[i];
      if (CHK != 0 && x != fq[fq.size() - 1]) begin
        m_code = 2'd2;
        push_exp(1'b1, c + 1, 1'b0, 2'd2);
      end else begin
        m_op = fq[0];
        m_len = fq[1];
        for (int i = 0; i < int'(m_len); i++) exp_pl.push_back(fq[2 + i]);
        push_exp(1'b0, c + 1, fq[0] == OPS, m_code);
      end
    end
  endtask
  task automatic model_idle(input int c);
    if (in_f && c - last_d == T) begin
      in_f = 1'b0;
      m_code = 2'd3;
      push_exp(1'b1, c + 1, 1'b0, 2'd3);
    end
  endtask
  task automatic drive(input bit v, input logic [7:0] b);
    @(negedge CLOCK_50);
    rx_valid = v;
    rx_data = v ? b : 8'($urandom);
    if (v) model_byte(b, cyc);
    else model_idle(cyc);
  endtask
  task automatic send_sq(input bit gaps);
    foreach (sq[i]) begin
      if (gaps && $urandom_range(0, 15) >= 12) repeat ($urandom_range(1, T)) drive(1'b0, 8'h00);
      drive(1'b1, sq[i]);
    end
    sq.delete();
  endtask
  task automatic build(input logic [7:0] op, input logic [7:0] len, input bit good);
    logic [7:0] x;
    x = op ^ len;
    sq.push_back(SYNC);
    sq.push_back(op);
    sq.push_back(len);
    if (len <= MAXP) begin
      for (int i = 0; i < int'(len); i++) begin
        sq.push_back(8'($urandom));
        x ^= sq[sq.size() - 1];
      end
      if (CHK != 0) sq.push_back(good ? x : ~x);
    end
  endtask
  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    rx_valid = 1'b0;
    in_f = 1'b0;
    m_op = 8'h00;
    m_len = 8'h00;
    m_code = 2'd0;
    @(negedge CLOCK_50);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_start_tx", start_tx, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_cmd_op", cmd_op, 0);
    chk("rst_cmd_len", cmd_len, 0);
  endtask
  initial begin
    bit e_err, e_stx;
    int e_at;
    logic [7:0] e_op, e_len;
    logic [1:0] e_code;
    forever begin
      @(negedge CLOCK_50);
      if (cmd_valid || frame_err) begin
        if (exp_at.size() == 0) chk("unexpected_pulse", {cmd_valid, frame_err}, 0);
        else begin
          e_err = exp_err.pop_front();
          e_at = exp_at.pop_front();
          e_stx = exp_stx.pop_front();
          e_op = exp_op.pop_front();
          e_len = exp_len.pop_front();
          e_code = exp_code.pop_front();
          chk("pulse_cycle", cyc, e_at);
          chk("cmd_valid", cmd_valid, !e_err);
          chk("frame_err", frame_err, e_err);
          chk("start_tx", start_tx, e_stx);
          chk("cmd_op", cmd_op, e_op);
          chk("cmd_len", cmd_len, e_len);
          chk("err_code", err_code, e_code);
          chk("busy_at_pulse", busy, 0);
          if (!e_err)
            for (int i = 0; i < int'(e_len); i++) begin
              buf_rd_addr = AW'(i);
              #1;
              chk("buf_byte", buf_rd_data, exp_pl.pop_front());
            end
        end
      end else if (exp_at.size() != 0 && exp_at[0] < cyc) begin
        chk("missing_pulse", cyc, exp_at[0]);
        e_err = exp_err.pop_front();
        e_len = exp_len.pop_front();
        void'(exp_at.pop_front());
        void'(exp_stx.pop_front());
        void'(exp_op.pop_front());
        void'(exp_code.pop_front());
        if (!e_err) repeat (int'(e_len)) void'(exp_pl.pop_front());
      end
    end
  end
  initial begin
    int r, k;
    logic [7:0] op, len;
    do_reset();
    sq = '{SYNC, 8'h02, 8'h02, 8'h11, 8'h22};
    if (CHK != 0) sq.push_back(8'h33);
    send_sq(1'b0);
    repeat (2) drive(1'b0, 8'h00);
    sq = '{8'h00, 8'hFF, SYNC, 8'h05, 8'h00};
    if (CHK != 0) sq.push_back(8'h05);
    send_sq(1'b0);
    sq = '{SYNC, 8'h01, 8'h11};
    send_sq(1'b0);
    sq = '{SYNC, 8'h01, 8'h00};
    if (CHK != 0) sq.push_back(8'h01);
    send_sq(1'b0);
    if (CHK != 0) begin
      sq = '{SYNC, 8'h01, 8'h01, 8'h7E, 8'h00};
      send_sq(1'b0);
    end
    drive(1'b1, SYNC);
    drive(1'b1, 8'h03);
    chk("busy_after_sync", busy, 1);
    repeat (T + 3) drive(1'b0, 8'h00);
    drive(1'b1, SYNC);
    drive(1'b1, 8'h03);
    repeat (T - 1) drive(1'b0, 8'h00);
    drive(1'b1, 8'h00);
    if (CHK != 0) drive(1'b1, 8'h03);
    repeat (T + 3) drive(1'b0, 8'h00);
    drive(1'b1, SYNC);
    drive(1'b1, 8'h03);
    do_reset();
    build(OPS, 8'd3, 1'b1);
    send_sq(1'b0);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      op = $urandom_range(0, 3) == 0 ? OPS : 8'($urandom);
      len = 8'($urandom_range(0, MAXP));
      if (r == 0) repeat ($urandom_range(1, 3)) drive(1'b1, 8'($urandom));
      else if (r == 1) begin
        build(op, 8'($urandom_range(MAXP + 1, 255)), 1'b1);
        send_sq(1'b1);
      end else if (r == 2) begin
        build(op, len, CHK == 0);
        send_sq(1'b1);
      end else if (r == 3) begin
        build(op, len, 1'b1);
        k = $urandom_range(2, sq.size() - 1);
        while (sq.size() > k) void'(sq.pop_back());
        send_sq(1'b1);
        repeat (T + 2) drive(1'b0, 8'h00);
      end else begin
        build(op, len, 1'b1);
        send_sq(1'b1);
      end
      repeat ($urandom_range(0, 2)) drive(1'b0, 8'h00);
    end
    repeat (2 * T + 4) drive(1'b0, 8'h00);
    chk("scoreboard_drained", exp_at.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
